// File: rtl/hazard_controller_if.sv
// Decoder/pipeline-side signal bundle for hazard_controller: hazard inputs from ID/EX/MEM/WB
// and the enables, bubbles, flush and forwarding selects it drives back.
interface hazard_if #(parameter int RA_W = 5);
    logic [RA_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic            id_uses_rs, id_uses_rt;
    logic            ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write;
    logic            branch_taken, dmem_req, dmem_ready;
    logic            pc_en, ifid_en, idex_en, exmem_en;
    logic            ifid_flush, bubble, memwb_bubble;
    logic [1:0]      fwd_a, fwd_b;
    logic            mem_timeout;
    logic [15:0]     stall_cnt, flush_cnt;

    modport master (
        output id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
               id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write,
               mem_reg_write, wb_reg_write, branch_taken, dmem_req, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, bubble, memwb_bubble,
               fwd_a, fwd_b, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
               id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write,
               mem_reg_write, wb_reg_write, branch_taken, dmem_req, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, bubble, memwb_bubble,
               fwd_a, fwd_b, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_controller.sv
// 5-stage MIPS hazard unit: load-use stall, branch flush, dmem wait-state FSM with timeout, forwarding.
// Outputs are combinational from inputs and state. HAZARD_PERF_EN enables the stall/flush counters.
module hazard_controller #(
    parameter int RA_W        = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input logic    clk,
    input logic    reset_n,
    hazard_if.slave hz
);

    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERROR} state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_timeout_q, mem_timeout_d;
    logic [8:0] wait_inc;
    logic       lu, memstall;
    logic       pc_en_c, ifid_en_c, idex_en_c, exmem_en_c;
    logic       ifid_flush_c, bubble_c, memwb_bubble_c;

    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] src,
        input logic            m_we, input logic [RA_W-1:0] m_rd,
        input logic            w_we, input logic [RA_W-1:0] w_rd
    );
        if (m_we && m_rd != RA_W'(0) && m_rd == src)      return 2'b10;
        else if (w_we && w_rd != RA_W'(0) && w_rd == src) return 2'b01;
        else                                              return 2'b00;
    endfunction

    assign lu = hz.ex_mem_read && (hz.ex_rd != RA_W'(0)) &&
                ((hz.id_uses_rs && hz.id_rs == hz.ex_rd) ||
                 (hz.id_uses_rt && hz.id_rt == hz.ex_rd));
    assign memstall = hz.dmem_req && !hz.dmem_ready;
    assign wait_inc = {1'b0, wait_q} + 9'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_RUN;
            wait_q        <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        mem_timeout_d = mem_timeout_q;
        unique case (state_q)
            S_RUN: begin
                if (memstall) begin
                    wait_d  = 8'd1;
                    state_d = S_MEM_WAIT;
                    // A timeout of 1 expires on the very first stalled cycle
                    if (9'd1 >= 9'(MEM_TIMEOUT)) begin
                        state_d       = S_ERROR;
                        mem_timeout_d = 1'b1;
                    end
                end
            end
            S_MEM_WAIT: begin
                if (!memstall) begin
                    wait_d  = 8'd0;
                    state_d = S_RUN;
                end else begin
                    wait_d = wait_inc[7:0];
                    if (wait_inc >= 9'(MEM_TIMEOUT)) begin
                        state_d       = S_ERROR;
                        mem_timeout_d = 1'b1;
                    end
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_RUN;
        endcase
    end

    // Priority: reset, ERROR, memory stall, taken branch, load-use, normal flow
    always_comb begin
        pc_en_c        = 1'b1;
        ifid_en_c      = 1'b1;
        idex_en_c      = 1'b1;
        exmem_en_c     = 1'b1;
        ifid_flush_c   = 1'b0;
        bubble_c       = 1'b0;
        memwb_bubble_c = 1'b0;
        if (!reset_n || state_q == S_ERROR) begin
            {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b0000;
            bubble_c       = 1'b1;
            memwb_bubble_c = 1'b1;
        end else if (memstall) begin
            {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b0000;
            memwb_bubble_c = 1'b1;
        end else if (hz.branch_taken) begin
            ifid_flush_c = 1'b1;
            bubble_c     = 1'b1;
        end else if (lu) begin
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
            bubble_c  = 1'b1;
        end
    end

    assign hz.pc_en        = pc_en_c;
    assign hz.ifid_en      = ifid_en_c;
    assign hz.idex_en      = idex_en_c;
    assign hz.exmem_en     = exmem_en_c;
    assign hz.ifid_flush   = ifid_flush_c;
    assign hz.bubble       = bubble_c;
    assign hz.memwb_bubble = memwb_bubble_c;
    assign hz.mem_timeout  = mem_timeout_q;
    assign hz.fwd_a = reset_n ? fwd_sel(hz.ex_rs, hz.mem_reg_write, hz.mem_rd,
                                        hz.wb_reg_write, hz.wb_rd) : 2'b00;
    assign hz.fwd_b = reset_n ? fwd_sel(hz.ex_rt, hz.mem_reg_write, hz.mem_rd,
                                        hz.wb_reg_write, hz.wb_rd) : 2'b00;

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en_c && state_q != S_ERROR && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (ifid_flush_c && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = 16'h0000;
    assign hz.flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios with literal expectations plus randomized
// traffic, all outputs compared every cycle against a cycle-count model of the hazard rules.
module tb_hazard_controller;

    localparam int RA_W = 5;
    localparam int MEM_TIMEOUT = 15;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    hazard_if #(.RA_W(RA_W)) hz ();

    hazard_controller #(.RA_W(RA_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .hz(hz.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: sticky error, consecutive stalled cycles, event counts
    bit m_err;
    int m_wait, m_stall, m_flush;

    function automatic logic [1:0] m_fwd(input int src);
        if (hz.mem_reg_write && hz.mem_rd != 0 && int'(hz.mem_rd) == src) return 2'b10;
        if (hz.wb_reg_write && hz.wb_rd != 0 && int'(hz.wb_rd) == src)    return 2'b01;
        return 2'b00;
    endfunction

    always @(negedge clk) begin : compare
        bit e_pc, e_ifid, e_idex, e_exmem, e_flush, e_bub, e_mwb, lu, ms;
        logic [1:0] e_fa, e_fb;
        if (!reset_n) begin
            m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end
        lu = hz.ex_mem_read && hz.ex_rd != 0 &&
             ((hz.id_uses_rs && hz.id_rs == hz.ex_rd) || (hz.id_uses_rt && hz.id_rt == hz.ex_rd));
        ms = hz.dmem_req && !hz.dmem_ready;
        {e_pc, e_ifid, e_idex, e_exmem, e_flush, e_bub, e_mwb} = 7'b1111_000;
        e_fa = reset_n ? m_fwd(int'(hz.ex_rs)) : 2'b00;
        e_fb = reset_n ? m_fwd(int'(hz.ex_rt)) : 2'b00;
        if (!reset_n || m_err) {e_pc, e_ifid, e_idex, e_exmem, e_flush, e_bub, e_mwb} = 7'b0000_011;
        else if (ms)           {e_pc, e_ifid, e_idex, e_exmem, e_flush, e_bub, e_mwb} = 7'b0000_001;
        else if (hz.branch_taken) {e_flush, e_bub} = 2'b11;
        else if (lu)           {e_pc, e_ifid, e_bub} = 3'b001;

        chk("pc_en", int'(hz.pc_en), int'(e_pc));
        chk("ifid_en", int'(hz.ifid_en), int'(e_ifid));
        chk("idex_en", int'(hz.idex_en), int'(e_idex));
        chk("exmem_en", int'(hz.exmem_en), int'(e_exmem));
        chk("ifid_flush", int'(hz.ifid_flush), int'(e_flush));
        chk("bubble", int'(hz.bubble), int'(e_bub));
        chk("memwb_bubble", int'(hz.memwb_bubble), int'(e_mwb));
        chk("fwd_a", int'(hz.fwd_a), int'(e_fa));
        chk("fwd_b", int'(hz.fwd_b), int'(e_fb));
        chk("mem_timeout", int'(hz.mem_timeout), int'(m_err));
        chk("stall_cnt", int'(hz.stall_cnt), m_stall);
        chk("flush_cnt", int'(hz.flush_cnt), m_flush);

        // Advance the model across the coming rising edge
        if (reset_n && !m_err) begin
            if (ms) begin
                m_wait++;
                if (m_wait >= MEM_TIMEOUT) m_err = 1;
            end else m_wait = 0;
            if (PERF && !e_pc && m_stall < 65535) m_stall++;
            if (PERF && e_flush && m_flush < 65535) m_flush++;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic probe();
        @(negedge clk); #1;
    endtask

    task automatic idle();
        hz.id_rs = '0; hz.id_rt = '0; hz.ex_rs = '0; hz.ex_rt = '0; hz.ex_rd = '0;
        hz.mem_rd = '0; hz.wb_rd = '0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
        hz.ex_mem_read = 0; hz.ex_reg_write = 0; hz.mem_reg_write = 0; hz.wb_reg_write = 0;
        hz.branch_taken = 0; hz.dmem_req = 0; hz.dmem_ready = 0;
    endtask

    // Async reset asserted between edges, held across one falling edge, released off-edge
    task automatic mid_reset(input string tag);
        #2 reset_n = 0;
        #1;
        chk({tag, "_rst_pc_en"}, int'(hz.pc_en), 0);
        chk({tag, "_rst_bubble"}, int'(hz.bubble), 1);
        chk({tag, "_rst_mwb"}, int'(hz.memwb_bubble), 1);
        chk({tag, "_rst_timeout"}, int'(hz.mem_timeout), 0);
        chk({tag, "_rst_stall_cnt"}, int'(hz.stall_cnt), 0);
        @(posedge clk); #2 reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "bench watchdog");
    end

    initial begin
        idle();
        #3;
        chk("reset_pc_en", int'(hz.pc_en), 0);
        chk("reset_bubble", int'(hz.bubble), 1);
        @(posedge clk); @(posedge clk); #2 reset_n = 1;
        step(); step();

        // Load-use: one stall cycle, then free flow
        hz.ex_mem_read = 1; hz.ex_rd = 5'd8; hz.id_rs = 5'd8; hz.id_uses_rs = 1;
        probe();
        chk("lu_pc_en", int'(hz.pc_en), 0);
        chk("lu_ifid_en", int'(hz.ifid_en), 0);
        chk("lu_idex_en", int'(hz.idex_en), 1);
        chk("lu_bubble", int'(hz.bubble), 1);
        step(); idle();
        probe();
        chk("lu_after_pc_en", int'(hz.pc_en), 1);
        chk("lu_stall_cnt", int'(hz.stall_cnt), PERF ? 1 : 0);

        // Forwarding priority and register-0 exclusion
        step();
        hz.mem_reg_write = 1; hz.mem_rd = 5'd5; hz.wb_reg_write = 1; hz.wb_rd = 5'd5;
        hz.ex_rs = 5'd5; hz.ex_rt = 5'd5;
        probe();
        chk("fwd_a_exmem", int'(hz.fwd_a), 2);
        chk("fwd_b_exmem", int'(hz.fwd_b), 2);
        step(); hz.mem_rd = 5'd0;
        probe();
        chk("fwd_a_memwb", int'(hz.fwd_a), 1);
        step(); hz.wb_rd = 5'd0; hz.ex_rs = 5'd0; hz.ex_rt = 5'd0;
        probe();
        chk("fwd_a_r0", int'(hz.fwd_a), 0);
        chk("fwd_b_r0", int'(hz.fwd_b), 0);

        // Branch and load-use together: flush wins, no stall
        step(); idle();
        hz.branch_taken = 1; hz.ex_mem_read = 1; hz.ex_rd = 5'd3; hz.id_rt = 5'd3; hz.id_uses_rt = 1;
        probe();
        chk("br_flush", int'(hz.ifid_flush), 1);
        chk("br_bubble", int'(hz.bubble), 1);
        chk("br_pc_en", int'(hz.pc_en), 1);
        step(); idle();
        probe();
        chk("br_flush_cnt", int'(hz.flush_cnt), PERF ? 1 : 0);
        chk("br_stall_cnt", int'(hz.stall_cnt), PERF ? 1 : 0);

        // Three wait states, released on ready
        for (int i = 0; i < 3; i++) begin
            step(); hz.dmem_req = 1; hz.dmem_ready = 0;
            probe();
            chk("wait_pc_en", int'(hz.pc_en), 0);
            chk("wait_mwb", int'(hz.memwb_bubble), 1);
        end
        step(); hz.dmem_ready = 1;
        probe();
        chk("wait_release_pc_en", int'(hz.pc_en), 1);
        chk("wait_release_exmem_en", int'(hz.exmem_en), 1);
        step(); idle();
        probe();
        chk("wait_timeout_clear", int'(hz.mem_timeout), 0);
        chk("wait_stall_cnt", int'(hz.stall_cnt), PERF ? 4 : 0);

        // Timeout after exactly MEM_TIMEOUT stalled cycles
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            step(); hz.dmem_req = 1; hz.dmem_ready = 0;
            probe();
            chk("to_pending", int'(hz.mem_timeout), 0);
        end
        step(); hz.dmem_ready = 1;
        probe();
        chk("to_flag", int'(hz.mem_timeout), 1);
        chk("to_pc_en", int'(hz.pc_en), 0);
        step(); idle(); hz.branch_taken = 1;
        probe();
        chk("to_no_flush", int'(hz.ifid_flush), 0);
        chk("to_stall_cnt", int'(hz.stall_cnt), PERF ? 4 + MEM_TIMEOUT : 0);
        step(); idle();
        mid_reset("err");

        // Reset in the middle of a wait state
        step(); hz.dmem_req = 1;
        step();
        mid_reset("wait");
        idle();
        probe();
        chk("post_reset_pc_en", int'(hz.pc_en), 1);

        // Random traffic with small register numbers to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            step();
            hz.id_rs = RA_W'($urandom_range(0, 3)); hz.id_rt = RA_W'($urandom_range(0, 3));
            hz.ex_rs = RA_W'($urandom_range(0, 3)); hz.ex_rt = RA_W'($urandom_range(0, 3));
            hz.ex_rd = RA_W'($urandom_range(0, 3)); hz.mem_rd = RA_W'($urandom_range(0, 3));
            hz.wb_rd = RA_W'($urandom_range(0, 3));
            hz.id_uses_rs = 1'($urandom_range(0, 1)); hz.id_uses_rt = 1'($urandom_range(0, 1));
            hz.ex_mem_read = ($urandom_range(0, 2) == 0);
            hz.ex_reg_write = 1'($urandom_range(0, 1));
            hz.mem_reg_write = 1'($urandom_range(0, 1));
            hz.wb_reg_write = 1'($urandom_range(0, 1));
            hz.branch_taken = ($urandom_range(0, 5) == 0);
            hz.dmem_req = ($urandom_range(0, 3) == 0) || (c % 700 > 670);
            hz.dmem_ready = (c % 700 > 670) ? 1'b0 : 1'($urandom_range(0, 1));
            if (c % 500 == 250) mid_reset("rand");
        end
        step(); idle();
        probe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
